// File: rtl/elevator_pkg.sv
// Shared definitions for the elevator floor sequencer and the button/LED request latch.
package elevator_pkg;

  localparam int FLOOR_W = 2;

  localparam logic [FLOOR_W-1:0] labelF1 = 2'b00;
  localparam logic [FLOOR_W-1:0] labelF2 = 2'b01;
  localparam logic [FLOOR_W-1:0] labelF3 = 2'b10;

  typedef enum logic [1:0] {IDLE, MOVE, ARRIVE, DOOR_OPEN} state_t;

  function automatic int cnt_width(int a, int b);
    int m;
    int w;
    m = (a > b) ? a : b;
    w = $clog2(m);
    return (w < 1) ? 1 : w;
  endfunction

  function automatic logic [FLOOR_W-1:0] next_floor(logic [FLOOR_W-1:0] f, logic up);
    return up ? f + FLOOR_W'(1) : f - FLOOR_W'(1);
  endfunction

endpackage

// File: rtl/elevator_timer.sv
// Loadable down-counter with a zero flag, shared by car travel and door dwell.
module elevator_timer #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] count;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      count <= '0;
    else if (load)
      count <= load_val;
    else if (dec && count != '0)
      count <= count - W'(1);
  end

  assign zero = (count == '0);

endmodule

// File: rtl/elevator_controller.sv
// Three-floor car sequencer: serves latched requests with a keep-direction (SCAN) policy.
// state     | meaning
// IDLE      | stopped, door shut, waiting for any request
// MOVE      | travelling one floor, timer counts down the travel time
// ARRIVE    | just reached a floor, decide stop or continue
// DOOR_OPEN | door dwell, latch clears the request at this floor
module elevator_controller
  import elevator_pkg::*;
#(
  parameter int TRAVEL_CYCLES = 4,
  parameter int DOOR_CYCLES   = 3
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               req1,
  input  logic               req2,
  input  logic               req3,
  output logic [FLOOR_W-1:0] floor,
  output logic               move_handler,
  output logic               dir_up,
  output logic               door_open
);

  localparam int CNT_W = cnt_width(TRAVEL_CYCLES, DOOR_CYCLES);
  localparam logic [CNT_W-1:0] TRAVEL_LOAD = CNT_W'(TRAVEL_CYCLES - 1);
  localparam logic [CNT_W-1:0] DOOR_LOAD   = CNT_W'(DOOR_CYCLES - 1);

  state_t           state;
  logic             first_dwell;
  logic             req_here, req_above, req_below;
  logic             go_up, go_any, stop_here, repress;
  logic             tmr_load, tmr_dec, tmr_zero;
  logic [CNT_W-1:0] tmr_val;

  always_comb begin
    req_here  = 1'b0;
    req_above = 1'b0;
    req_below = 1'b0;
    case (floor)
      labelF1: begin req_here = req1; req_above = req2 | req3; end
      labelF2: begin req_here = req2; req_above = req3; req_below = req1; end
      default: begin req_here = req3; req_below = req1 | req2; end
    endcase
  end

  assign go_any    = req_above | req_below;
  assign go_up     = req_above & (dir_up | ~req_below);
  assign stop_here = req_here | (dir_up ? ~req_above : ~req_below);
  // The first dwell cycle after ARRIVE still sees the LED the latch is about to clear.
  assign repress   = req_here & ~first_dwell;

  always_comb begin
    tmr_load = 1'b0;
    tmr_dec  = 1'b0;
    tmr_val  = TRAVEL_LOAD;
    case (state)
      IDLE: begin
        tmr_load = req_here | go_any;
        if (req_here) tmr_val = DOOR_LOAD;
      end
      MOVE: tmr_dec = 1'b1;
      ARRIVE: begin
        tmr_load = 1'b1;
        if (stop_here) tmr_val = DOOR_LOAD;
      end
      DOOR_OPEN: begin
        if (repress) begin
          tmr_load = 1'b1;
          tmr_val  = DOOR_LOAD;
        end else if (tmr_zero) begin
          tmr_load = go_any;
        end else begin
          tmr_dec = 1'b1;
        end
      end
      default: ;
    endcase
  end

  elevator_timer #(.W(CNT_W)) u_timer (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (tmr_load),
    .load_val (tmr_val),
    .dec      (tmr_dec),
    .zero     (tmr_zero)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      floor        <= labelF1;
      dir_up       <= 1'b1;
      move_handler <= 1'b0;
      door_open    <= 1'b0;
      first_dwell  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_here) begin
            state       <= DOOR_OPEN;
            door_open   <= 1'b1;
            first_dwell <= 1'b1;
          end else if (go_any) begin
            state        <= MOVE;
            dir_up       <= go_up;
            move_handler <= 1'b1;
          end
        end
        MOVE: begin
          if (tmr_zero) begin
            floor <= next_floor(floor, dir_up);
            state <= ARRIVE;
          end
        end
        ARRIVE: begin
          if (stop_here) begin
            state        <= DOOR_OPEN;
            move_handler <= 1'b0;
            door_open    <= 1'b1;
            first_dwell  <= 1'b1;
          end else begin
            state <= MOVE;
          end
        end
        DOOR_OPEN: begin
          first_dwell <= 1'b0;
          if (!repress && tmr_zero) begin
            door_open <= 1'b0;
            if (go_any) begin
              state        <= MOVE;
              dir_up       <= go_up;
              move_handler <= 1'b1;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_elevator_controller.sv
// Bench for elevator_controller: models the request latch and scoreboards cycle-exact car outputs.
module tb_elevator_controller;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       req1, req2, req3;
  logic [1:0] floor;
  logic       move_handler, dir_up, door_open;
  logic [2:0] press = '0;
  logic [2:0] led;
  logic [4:0] obs;

  int cyc = 0;
  int n_checks = 0;
  int n_fail = 0;

  typedef struct {
    int         at;
    logic [4:0] val;
    string      nm;
  } exp_t;

  exp_t sb[$];
  exp_t cur;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Request latch: a press sets the LED (and wins), a stopped car clears its floor's LED.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) led <= '0;
    else
      for (int i = 0; i < 3; i++)
        led[i] <= press[i] | (led[i] & ~(!move_handler && floor == 2'(i)));
  end

  assign req1 = led[0];
  assign req2 = led[1];
  assign req3 = led[2];
  assign obs  = {floor, move_handler, door_open, dir_up};

  elevator_controller #(.TRAVEL_CYCLES(4), .DOOR_CYCLES(3)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .req1         (req1),
    .req2         (req2),
    .req3         (req3),
    .floor        (floor),
    .move_handler (move_handler),
    .dir_up       (dir_up),
    .door_open    (door_open)
  );

  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].at <= cyc) begin
      cur = sb.pop_front();
      n_checks++;
      if (cur.at != cyc) begin
        n_fail++;
        $display("FAIL %s: expectation for cycle %0d skipped at cycle %0d", cur.nm, cur.at, cyc);
      end else if (obs !== cur.val) begin
        n_fail++;
        $display("FAIL %s @%0d: got floor=%b mh=%b door=%b dir=%b, want floor=%b mh=%b door=%b dir=%b",
                 cur.nm, cyc, obs[4:3], obs[2], obs[1], obs[0],
                 cur.val[4:3], cur.val[2], cur.val[1], cur.val[0]);
      end
    end
  end

  function automatic void push(int at, logic [1:0] f, logic mh, logic d, logic dir, string nm);
    exp_t e;
    e.at  = at;
    e.val = {f, mh, d, dir};
    e.nm  = nm;
    sb.push_back(e);
  endfunction

  task automatic pulse(input logic [2:0] m);
    press = m;
    @(negedge clk);
    press = '0;
  endtask

  task automatic drain(input string nm);
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL %s: %0d expectations never reached", nm, sb.size());
      sb.delete();
    end
  endtask

  task automatic go_to(input int idx);
    int t;
    pulse(3'b001 << idx);
    t = 0;
    while (!(door_open && floor == 2'(idx)) && t < 60) begin
      @(negedge clk);
      t++;
    end
    n_checks++;
    if (t >= 60) begin
      n_fail++;
      $display("FAIL go_to_%0d: floor=%b door=%b after 60 cycles, want floor=%0d with door open",
               idx, floor, door_open, idx);
    end
    t = 0;
    while (door_open && t < 10) begin
      @(negedge clk);
      t++;
    end
    n_checks++;
    if (door_open !== 1'b0) begin
      n_fail++;
      $display("FAIL go_to_%0d_close: door_open=%b, want 0", idx, door_open);
    end
  endtask

  task automatic test_reset();
    int base;
    n_checks++;
    if (obs !== 5'b00001) begin
      n_fail++;
      $display("FAIL reset_values: got %b, want 00001", obs);
    end
    reset_n = 1'b1;
    @(negedge clk);
    base = cyc;
    pulse(3'b100);
    repeat (7) @(negedge clk);
    n_checks++;
    if (floor !== 2'b01 || move_handler !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_premove: got floor=%b mh=%b, want floor=01 mh=1", floor, move_handler);
    end
    reset_n = 1'b0;
    #1;
    n_checks++;
    if (obs !== 5'b00001) begin
      n_fail++;
      $display("FAIL reset_midmove: got %b, want 00001", obs);
    end
    @(negedge clk);
    reset_n = 1'b1;
    base = cyc;
    for (int k = 1; k <= 10; k++) push(base + k, 2'b00, 1'b0, 1'b0, 1'b1, "rst_idle");
    repeat (11) @(negedge clk);
    drain("reset");
  endtask

  task automatic test_travel_up();
    int base;
    base = cyc;
    push(base + 1,  2'b00, 1, 0, 1, "up_wait");
    push(base + 2,  2'b00, 1, 0, 1, "up_depart");
    push(base + 5,  2'b00, 1, 0, 1, "up_f1_hold");
    push(base + 6,  2'b01, 1, 0, 1, "up_at_f2");
    push(base + 7,  2'b01, 1, 0, 1, "up_pass_f2");
    push(base + 10, 2'b01, 1, 0, 1, "up_f2_hold");
    push(base + 11, 2'b10, 1, 0, 1, "up_at_f3");
    push(base + 12, 2'b10, 0, 1, 1, "up_door");
    push(base + 14, 2'b10, 0, 1, 1, "up_door_last");
    push(base + 15, 2'b10, 0, 0, 1, "up_closed");
    sb[0].val = {2'b00, 1'b0, 1'b0, 1'b1};
    pulse(3'b100);
    repeat (15) @(negedge clk);
    n_checks++;
    if (led !== 3'b000) begin
      n_fail++;
      $display("FAIL up_req3_cleared: leds=%b, want 000", led);
    end
    drain("travel_up");
  endtask

  task automatic test_travel_down();
    int base;
    base = cyc;
    push(base + 1,  2'b10, 0, 0, 1, "dn_wait");
    push(base + 2,  2'b10, 1, 0, 0, "dn_depart");
    push(base + 6,  2'b01, 1, 0, 0, "dn_at_f2");
    push(base + 7,  2'b01, 1, 0, 0, "dn_pass_f2");
    push(base + 11, 2'b00, 1, 0, 0, "dn_at_f1");
    push(base + 12, 2'b00, 0, 1, 0, "dn_door");
    push(base + 15, 2'b00, 0, 0, 0, "dn_closed");
    pulse(3'b001);
    repeat (15) @(negedge clk);
    drain("travel_down");
  endtask

  task automatic test_intermediate();
    int base;
    base = cyc;
    push(base + 2,  2'b00, 1, 0, 1, "mid_depart");
    push(base + 6,  2'b01, 1, 0, 1, "mid_arrive_f2");
    push(base + 7,  2'b01, 0, 1, 1, "mid_stop_f2");
    push(base + 9,  2'b01, 0, 1, 1, "mid_door_last");
    push(base + 10, 2'b01, 1, 0, 1, "mid_resume");
    push(base + 13, 2'b01, 1, 0, 1, "mid_hold");
    push(base + 14, 2'b10, 1, 0, 1, "mid_at_f3");
    push(base + 15, 2'b10, 0, 1, 1, "mid_door_f3");
    push(base + 17, 2'b10, 0, 1, 1, "mid_door_f3_last");
    push(base + 18, 2'b10, 0, 0, 1, "mid_closed");
    pulse(3'b100);
    repeat (2) @(negedge clk);
    pulse(3'b010);
    repeat (15) @(negedge clk);
    drain("intermediate");
  endtask

  task automatic test_direction_priority();
    int base;
    base = cyc;
    push(base + 2,  2'b00, 1, 0, 1, "pri_depart");
    push(base + 6,  2'b01, 1, 0, 1, "pri_at_f2");
    push(base + 7,  2'b01, 0, 1, 1, "pri_door_f2");
    push(base + 10, 2'b01, 1, 0, 1, "pri_up_first");
    push(base + 14, 2'b10, 1, 0, 1, "pri_at_f3");
    push(base + 15, 2'b10, 0, 1, 1, "pri_door_f3");
    push(base + 18, 2'b10, 1, 0, 0, "pri_reverse");
    push(base + 22, 2'b01, 1, 0, 0, "pri_pass_f2");
    push(base + 23, 2'b01, 1, 0, 0, "pri_keep_moving");
    push(base + 27, 2'b00, 1, 0, 0, "pri_at_f1");
    push(base + 28, 2'b00, 0, 1, 0, "pri_door_f1");
    push(base + 31, 2'b00, 0, 0, 0, "pri_closed");
    pulse(3'b010);
    repeat (6) @(negedge clk);
    pulse(3'b101);
    repeat (24) @(negedge clk);
    drain("direction_priority");
  endtask

  task automatic test_same_floor();
    int base;
    base = cyc;
    push(base + 1, 2'b00, 0, 0, 0, "here_wait");
    push(base + 2, 2'b00, 0, 1, 0, "here_door");
    push(base + 4, 2'b00, 0, 1, 0, "here_repress");
    push(base + 5, 2'b00, 0, 1, 0, "here_extended");
    push(base + 6, 2'b00, 0, 1, 0, "here_extended_last");
    push(base + 7, 2'b00, 0, 0, 0, "here_closed");
    pulse(3'b001);
    @(negedge clk);
    pulse(3'b001);
    repeat (5) @(negedge clk);
    drain("same_floor");
  endtask

  task automatic test_boundary_f3();
    int base;
    go_to(2);
    base = cyc;
    push(base + 1, 2'b10, 0, 0, 1, "f3_wait");
    push(base + 2, 2'b10, 0, 1, 1, "f3_door");
    push(base + 4, 2'b10, 0, 1, 1, "f3_door_last");
    push(base + 5, 2'b10, 0, 0, 1, "f3_closed");
    push(base + 8, 2'b10, 0, 0, 1, "f3_stays");
    pulse(3'b100);
    repeat (8) @(negedge clk);
    drain("boundary_f3");
  endtask

  task automatic test_random();
    int t;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      for (int b = 0; b < 3; b++) press[b] = ($urandom_range(0, 19) == 0);
      n_checks++;
      if (floor === 2'b11 || (move_handler && door_open) || $isunknown(obs)) begin
        n_fail++;
        $display("FAIL rand_invariant @%0d: floor=%b mh=%b door=%b", cyc, floor, move_handler, door_open);
      end
    end
    press = '0;
    t = 0;
    while (!(led == 3'b000 && !move_handler && !door_open) && t < 200) begin
      @(negedge clk);
      t++;
    end
    n_checks++;
    if (t >= 200) begin
      n_fail++;
      $display("FAIL rand_drain: leds=%b mh=%b door=%b after 200 cycles, want all served",
               led, move_handler, door_open);
    end
  endtask

  initial begin
    reset_n = 1'b0;
    press   = '0;
    repeat (3) @(negedge clk);
    test_reset();
    test_travel_up();
    test_travel_down();
    test_intermediate();
    go_to(0);
    test_direction_priority();
    test_same_floor();
    test_boundary_f3();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
